// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched
// Purpose  : Round-robin scheduler sharing one WIDTH-bit interval counter
//            among NREQ requesters. A granted requester sees the counter
//            run 0..L-1, followed by a one-cycle done pulse. Requesters that
//            drop req while running abort without a done pulse.
// Ports    : clk     - system clock, rising edge
//            reset   - synchronous, active-high, dominates all inputs
//            req     - per-requester request level
//            req_len - per-requester length L, slice i = [i*WIDTH +: WIDTH]
//            gnt     - registered one-hot grant
//            done    - registered one-cycle completion pulse
//            value   - shared counter value
//            busy    - high whenever a requester is granted
// Revision : 1.0 - initial release
// ============================================================================
module counter_sched #(
    parameter int WIDTH = 6,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      value,
    output logic                  busy
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state, w_state;
    logic [c_PW-1:0]  r_ptr,   w_ptr;
    logic [c_PW-1:0]  r_win,   w_win;
    logic [WIDTH-1:0] r_len,   w_len;
    logic [NREQ-1:0]  r_gnt,   w_gnt;
    logic [NREQ-1:0]  r_done,  w_done;
    logic [WIDTH-1:0] r_value, w_value;
    logic             r_busy,  w_busy;

    // Round-robin search results
    logic             w_found;
    logic [c_PW-1:0]  w_pick;
    logic [NREQ-1:0]  w_pick_oh;
    logic [WIDTH-1:0] w_pick_len;
    logic [c_PW-1:0]  w_ptr_after;

    // First set req bit at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = c_PW'(v_idx);
            end
        end
    end

    assign w_pick_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_pick_len  = req_len[int'(w_pick)*WIDTH +: WIDTH];
    // Priority moves past the requester that just finished or aborted.
    assign w_ptr_after = (r_win == c_PW'(NREQ-1)) ? '0 : r_win + 1'b1;

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_win   = r_win;
        w_len   = r_len;
        w_gnt   = r_gnt;
        w_done  = '0;
        w_value = r_value;
        w_busy  = r_busy;

        case (r_state)
            c_IDLE: begin
                w_gnt   = '0;
                w_value = '0;
                w_busy  = 1'b0;
                if (w_found) begin
                    w_win  = w_pick;
                    w_len  = w_pick_len;
                    w_gnt  = w_pick_oh;
                    w_busy = 1'b1;
                    if (w_pick_len == '0) begin
                        // Zero-length interval completes without counting.
                        w_state = c_DONE;
                        w_done  = w_pick_oh;
                    end else begin
                        w_state = c_RUN;
                    end
                end
            end
            c_RUN: begin
                if (!req[r_win]) begin
                    // Abort wins over completion on the same edge.
                    w_state = c_IDLE;
                    w_gnt   = '0;
                    w_value = '0;
                    w_busy  = 1'b0;
                    w_ptr   = w_ptr_after;
                end else if (r_value == r_len - 1'b1) begin
                    w_state = c_DONE;
                    w_done  = r_gnt;
                end else begin
                    w_value = r_value + 1'b1;
                end
            end
            c_DONE: begin
                w_state = c_IDLE;
                w_gnt   = '0;
                w_value = '0;
                w_busy  = 1'b0;
                w_ptr   = w_ptr_after;
            end
            default: begin
                w_state = c_IDLE;
                w_gnt   = '0;
                w_value = '0;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_len   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_value <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_win   <= w_win;
            r_len   <= w_len;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_value <= w_value;
            r_busy  <= w_busy;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign value = r_value;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sched
// Purpose  : Self-checking bench for counter_sched. A transaction-level
//            reference model tracks the active grant by its start edge and
//            length and pushes expected outputs into a queue each edge; a
//            monitor pops and compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sched;

    localparam int c_WIDTH = 6;
    localparam int c_NREQ  = 4;

    logic                      clk;
    logic                      reset;
    logic [c_NREQ-1:0]         req;
    logic [c_NREQ*c_WIDTH-1:0] req_len;
    logic [c_NREQ-1:0]         gnt;
    logic [c_NREQ-1:0]         done;
    logic [c_WIDTH-1:0]        value;
    logic                      busy;

    counter_sched #(.WIDTH(c_WIDTH), .NREQ(c_NREQ)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .done    (done),
        .value   (value),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_NREQ-1:0]  gnt;
        logic [c_NREQ-1:0]  done;
        logic [c_WIDTH-1:0] value;
        logic               busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- reference model ----------------
    // A grant started at edge e0 with length L occupies edges e0..e0+L+1.
    // After edge e0+k the counter shows k (k<L), the done cycle is k==L.
    int m_edge   = 0;
    bit m_active = 0;
    int m_ptr    = 0;
    int m_win    = 0;
    int m_len    = 0;
    int m_e0     = 0;

    always @(posedge clk) begin
        exp_t e;
        int   k;
        bit   found;
        m_edge++;
        if (reset) begin
            m_active = 0;
            m_ptr    = 0;
        end else if (!m_active) begin
            found = 0;
            for (int j = 0; j < c_NREQ; j++) begin
                int idx;
                idx = (m_ptr + j) % c_NREQ;
                if (!found && req[idx]) begin
                    found    = 1;
                    m_active = 1;
                    m_win    = idx;
                    m_len    = int'(req_len[idx*c_WIDTH +: c_WIDTH]);
                    m_e0     = m_edge;
                end
            end
        end else begin
            k = m_edge - m_e0;
            if (k == m_len + 1) begin
                m_active = 0;
                m_ptr    = (m_win + 1) % c_NREQ;
            end else if (!req[m_win]) begin
                m_active = 0;
                m_ptr    = (m_win + 1) % c_NREQ;
            end
        end

        e.gnt = '0; e.done = '0; e.value = '0; e.busy = 1'b0;
        if (m_active) begin
            k      = m_edge - m_e0;
            e.gnt  = c_NREQ'(1) << m_win;
            e.busy = 1'b1;
            if (k < m_len)       e.value = c_WIDTH'(k);
            else if (m_len == 0) e.value = '0;
            else                 e.value = c_WIDTH'(m_len - 1);
            if (k == m_len)      e.done = e.gnt;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",   int'(gnt),   int'(e.gnt));
            chk("done",  int'(done),  int'(e.done));
            chk("value", int'(value), int'(e.value));
            chk("busy",  int'(busy),  int'(e.busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int l);
        req_len[i*c_WIDTH +: c_WIDTH] = c_WIDTH'(l);
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_len = '0;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        // Single request, L=5
        set_len(0, 5); req = 4'b0001; cyc(7);
        req = '0; cyc(3);

        // Two requesters alternate
        set_len(0, 3); set_len(2, 2); req = 4'b0101; cyc(20);
        req = '0; cyc(3);

        // Zero length: grant and done together, period of 2
        set_len(1, 0); req = 4'b0010; cyc(6);
        req = '0; cyc(2);

        // Abort mid-count, then full contention
        set_len(3, 10); req = 4'b1000; cyc(6);
        req = '0; cyc(2);
        for (int i = 0; i < c_NREQ; i++) set_len(i, 2);
        req = 4'b1111; cyc(10);
        req = '0; cyc(4);

        // Reset in the middle of a run
        set_len(0, 15); req = 4'b0001; cyc(11);
        reset = 1'b1; cyc(1);
        reset = 1'b0; req = 4'b1111; cyc(12);
        req = '0; cyc(3);

        // Maximum length, no wrap
        set_len(0, 63); req = 4'b0001; cyc(70);
        req = '0; cyc(3);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < c_NREQ; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        if ($urandom_range(3) == 0) set_len(i, int'($urandom_range(63)));
                        else                        set_len(i, int'($urandom_range(5)));
                        req[i] = 1'b1;
                    end
                end else if (done[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                end else if ($urandom_range(39) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(9) == 0) begin
                    // Length changes after the grant must be ignored.
                    set_len(i, int'($urandom_range(63)));
                end
            end
            reset = ($urandom_range(499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        req   = '0;
        cyc(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
